// File: rtl/copro_sortp.sv
// Odd-even transposition sort co-processor: NW words of DW bits viewed as N elements of EW bits.
// Sorts one pass per clock, ascending/descending, unsigned/signed, with early exit once sorted.
module copro_sortp #(
  parameter int EW = 4,
  parameter int DW = 32,
  parameter int NW = 2
) (
  input  logic                                 ck,
  input  logic                                 rb,
  input  logic                                 start,
  input  logic                                 desc,
  input  logic                                 sgn,
  output logic                                 ready,
  output logic                                 busy,
  input  logic                                 dpsh,
  input  logic [DW-1:0]                        dinp,
  input  logic                                 dpop,
  output logic [DW-1:0]                        dout,
  output logic [$clog2(NW*DW/EW+1)-1:0]        npass,
  output logic                                 err
);

  localparam int TW = NW * DW;
  localparam int N  = TW / EW;
  localparam int PW = $clog2(N + 1);
  localparam logic [PW-1:0] LAST_P = PW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SORT = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [TW-1:0]   data_r;
  logic [TW-1:0]   nxt_s;
  logic [TW-1:0]   push_s;
  logic [TW-1:0]   rot_s;
  logic [PW-1:0]   pass_r;
  logic [PW-1:0]   npass_r;
  logic            desc_r;
  logic            sgn_r;
  logic            err_r;
  logic            ready_r;
  logic            prev_swp_r;
  logic            swp_s;
  logic            done_s;

  // Flipping the sign bit maps two's complement onto an order-preserving unsigned key.
  function automatic logic out_of_order(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                        input logic dsc, input logic sg);
    logic [EW-1:0] ka;
    logic [EW-1:0] kb;
    ka = a;
    kb = b;
    if (sg) begin
      ka[EW-1] = ~a[EW-1];
      kb[EW-1] = ~b[EW-1];
    end else begin
      ka = a;
      kb = b;
    end
    return dsc ? (ka < kb) : (ka > kb);
  endfunction

  generate
    if (NW == 1) begin : g_one
      assign push_s = dinp;
      assign rot_s  = data_r;
    end else begin : g_multi
      assign push_s = {data_r[TW-DW-1:0], dinp};
      assign rot_s  = {data_r[TW-DW-1:0], data_r[TW-1 -: DW]};
    end
  endgenerate

  // One compare-exchange pass; pair (i,i+1) is active when i has the parity of the pass.
  always_comb begin
    nxt_s = data_r;
    swp_s = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if ((i[0] == pass_r[0]) &&
          out_of_order(data_r[TW-1-i*EW -: EW], data_r[TW-1-(i+1)*EW -: EW], desc_r, sgn_r)) begin
        nxt_s[TW-1-i*EW -: EW]     = data_r[TW-1-(i+1)*EW -: EW];
        nxt_s[TW-1-(i+1)*EW -: EW] = data_r[TW-1-i*EW -: EW];
        swp_s                      = 1'b1;
      end else begin
        swp_s = swp_s;
      end
    end
  end

  // Finish on the last possible pass, or after two consecutive passes without a swap.
  always_comb begin
    done_s = (pass_r == LAST_P) ||
             ((pass_r != {PW{1'b0}}) && !swp_s && !prev_swp_r);
  end

  // Next-state logic; start always (re)enters SORT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = SORT;
        else       state_s = IDLE;
      end
      SORT: begin
        if (start)       state_s = SORT;
        else if (done_s) state_s = IDLE;
        else             state_s = SORT;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ck or negedge rb) begin
    if (!rb) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Data register, pass bookkeeping and host-visible status.
  always_ff @(posedge ck or negedge rb) begin
    if (!rb) begin
      data_r     <= {TW{1'b0}};
      pass_r     <= {PW{1'b0}};
      npass_r    <= {PW{1'b0}};
      desc_r     <= 1'b0;
      sgn_r      <= 1'b0;
      err_r      <= 1'b0;
      ready_r    <= 1'b0;
      prev_swp_r <= 1'b0;
    end else if (start) begin
      pass_r     <= {PW{1'b0}};
      npass_r    <= {PW{1'b0}};
      desc_r     <= desc;
      sgn_r      <= sgn;
      err_r      <= 1'b0;
      ready_r    <= 1'b0;
      prev_swp_r <= 1'b1;
    end else if (state_r == SORT) begin
      data_r     <= nxt_s;
      npass_r    <= pass_r + PW'(1);
      prev_swp_r <= swp_s;
      ready_r    <= done_s;
      if (!done_s) pass_r <= pass_r + PW'(1);
      else         pass_r <= pass_r;
      if (dpsh || dpop) err_r <= 1'b1;
      else              err_r <= err_r;
    end else begin
      ready_r <= 1'b0;
      if (dpsh)      data_r <= push_s;
      else if (dpop) data_r <= rot_s;
      else           data_r <= data_r;
    end
  end

  assign busy  = (state_r == SORT);
  assign ready = ready_r;
  assign err   = err_r;
  assign npass = npass_r;
  assign dout  = data_r[TW-1 -: DW];

endmodule
